// File: rtl/spi_xfer_sched.sv
// spi_xfer_sched: round-robin scheduler sharing one SPI master channel among NREQ requesters.
// Each grant programs CR1/BR, selects the slave, writes DR1, polls SR and reads DR2.
module spi_xfer_sched #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [3*NREQ-1:0] req_cs,
    input  logic [7:0]        cfg_cr1,
    input  logic [7:0]        cfg_br,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   err,
    output logic [7:0]        rsp_data,
    output logic              busy,
    output logic [2:0]        sfraddr_w,
    output logic              sfrwe,
    output logic [7:0]        spidata_o,
    output logic [2:0]        sfraddr_r,
    input  logic [7:0]        sfrdata_i,
    output logic [7:0]        spssn
);
    localparam int WW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {IDLE, CR1, BR, SEL, LOAD, WAIT, READ, DONE, ABORT} state_t;

    state_t        state_q;
    logic [WW-1:0] ptr_q, win_q, win_d, cand;
    logic          found_d;
    logic [7:0]    tx_q;
    logic [2:0]    cs_q;
    logic [CW-1:0] cnt_q;
    logic [NREQ-1:0] ack_q, err_q;
    logic [7:0]    rsp_q, wdata_q, spssn_q;
    logic [2:0]    waddr_q, raddr_q;
    logic          busy_q, sfrwe_q;

    // Walk downward so the lowest offset from ptr_q is the one that sticks.
    always_comb begin
        win_d   = ptr_q;
        found_d = 1'b0;
        cand    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = WW'((int'(ptr_q) + i) % NREQ);
            if (req[cand]) begin
                win_d   = cand;
                found_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            tx_q    <= '0;
            cs_q    <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            rsp_q   <= '0;
            busy_q  <= 1'b0;
            sfrwe_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            raddr_q <= 3'd3;
            spssn_q <= 8'hFF;
        end else begin
            ack_q   <= '0;
            err_q   <= '0;
            sfrwe_q <= 1'b0;
            case (state_q)
                IDLE: if (found_d) begin
                    state_q <= CR1;
                    win_q   <= win_d;
                    tx_q    <= req_data[8*win_d +: 8];
                    cs_q    <= req_cs[3*win_d +: 3];
                    busy_q  <= 1'b1;
                    sfrwe_q <= 1'b1;
                    waddr_q <= 3'd0;
                    wdata_q <= cfg_cr1 | 8'h10;
                end
                CR1: begin
                    state_q <= BR;
                    sfrwe_q <= 1'b1;
                    waddr_q <= 3'd2;
                    wdata_q <= cfg_br;
                end
                BR: begin
                    state_q <= SEL;
                    spssn_q <= ~(8'h01 << cs_q);
                end
                SEL: begin
                    state_q <= LOAD;
                    sfrwe_q <= 1'b1;
                    waddr_q <= 3'd3;
                    wdata_q <= tx_q;
                end
                LOAD: begin
                    state_q <= WAIT;
                    cnt_q   <= '0;
                    raddr_q <= 3'd3;
                end
                WAIT: begin
                    cnt_q <= (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
                    // Completion is checked first so it wins over a coincident timeout.
                    if (cnt_q >= CW'(2) && sfrdata_i[0]) begin
                        state_q <= READ;
                        raddr_q <= 3'd5;
                    end else if (cnt_q >= CW'(TIMEOUT - 1)) begin
                        state_q <= ABORT;
                        err_q   <= NREQ'(1) << win_q;
                        spssn_q <= 8'hFF;
                    end
                end
                READ: begin
                    state_q <= DONE;
                    rsp_q   <= sfrdata_i;
                    ack_q   <= NREQ'(1) << win_q;
                    spssn_q <= 8'hFF;
                    raddr_q <= 3'd3;
                end
                DONE, ABORT: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ptr_q   <= (win_q == WW'(NREQ - 1)) ? '0 : win_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack       = ack_q;
    assign err       = err_q;
    assign rsp_data  = rsp_q;
    assign busy      = busy_q;
    assign sfraddr_w = waddr_q;
    assign sfrwe     = sfrwe_q;
    assign spidata_o = wdata_q;
    assign sfraddr_r = raddr_q;
    assign spssn     = spssn_q;
endmodule

// File: tb/tb_spi_xfer_sched.sv
// tb_spi_xfer_sched: scoreboard bench for spi_xfer_sched with a simple SPI SFR model.
// Stimulus pushes expected SFR writes and ack/err responses; a negedge monitor pops and compares.
module tb_spi_xfer_sched;
    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [3*NREQ-1:0] req_cs = '0;
    logic [7:0]        cfg_cr1 = 8'h43;
    logic [7:0]        cfg_br = 8'h07;
    logic [NREQ-1:0]   ack, err;
    logic [7:0]        rsp_data, spidata_o, spssn, sfrdata_i;
    logic              busy, sfrwe, sr0;
    logic [2:0]        sfraddr_w, sfraddr_r;
    logic [7:0]        rx = '0;
    int cyc = 0, checks = 0, errors = 0, wcnt = 0, sr_delay = 3, sr_mode = 0;

    typedef struct {bit is_err; int idx; logic [7:0] data; int at; logic [7:0] ss;} exp_t;
    typedef struct {logic [2:0] a; logic [7:0] d;} wr_t;
    exp_t sb[$];
    wr_t  wq[$];
    exp_t mon_e;
    wr_t  mon_w;
    logic [NREQ-1:0] oh;

    spi_xfer_sched #(.NREQ(NREQ), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_cs(req_cs),
        .cfg_cr1(cfg_cr1), .cfg_br(cfg_br), .ack(ack), .err(err), .rsp_data(rsp_data),
        .busy(busy), .sfraddr_w(sfraddr_w), .sfrwe(sfrwe), .spidata_o(spidata_o),
        .sfraddr_r(sfraddr_r), .sfrdata_i(sfrdata_i), .spssn(spssn)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SPI model: DR1 write starts a transfer; rx byte is tx ^ 8'h99; SR[0] per sr_mode.
    always @(posedge clk) begin
        if (sfrwe && sfraddr_w == 3'd3) begin
            wcnt <= 0;
            rx   <= spidata_o ^ 8'h99;
        end else begin
            wcnt <= wcnt + 1;
        end
    end
    assign sr0 = (sr_mode == 1) ? 1'b1 : (sr_mode == 2) ? 1'b0 : (wcnt >= sr_delay);
    assign sfrdata_i = (sfraddr_r == 3'd5) ? rx : {7'd0, sr0};

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, a, e);
        end
    endtask

    task automatic push_wr(logic [7:0] tx);
        wq.push_back('{3'd0, 8'h53});
        wq.push_back('{3'd2, 8'h07});
        wq.push_back('{3'd3, tx});
    endtask

    task automatic issue(int i, logic [7:0] tx, logic [2:0] cs, logic [7:0] rsp, bit is_err, int at);
        req_data[8*i +: 8] = tx;
        req_cs[3*i +: 3]   = cs;
        req[i]             = 1'b1;
        push_wr(tx);
        sb.push_back('{is_err, i, rsp, at, ~(8'h01 << cs)});
    endtask

    task automatic wait_done(int budget);
        int n = 0;
        do begin
            @(negedge clk);
            req = req & ~(ack | err);
            n++;
        end while ((req != '0 || busy) && n < budget);
        checks++;
        if (req != '0 || busy) begin
            errors++;
            $display("FAIL wait_done budget expired req=%b busy=%b", req, busy);
            req = '0;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (sfrwe) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL sfr_write unexpected addr=%0d data=%h", sfraddr_w, spidata_o);
                end else begin
                    mon_w = wq.pop_front();
                    if (sfraddr_w !== mon_w.a || spidata_o !== mon_w.d) begin
                        errors++;
                        $display("FAIL sfr_write got %0d/%h expected %0d/%h", sfraddr_w, spidata_o, mon_w.a, mon_w.d);
                    end
                end
            end
            if (spssn !== 8'hFF) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL spssn low with nothing pending got %h", spssn);
                end else if (spssn !== sb[0].ss) begin
                    errors++;
                    $display("FAIL spssn got %h expected %h", spssn, sb[0].ss);
                end
            end
            if (ack != '0 || err != '0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL response unexpected ack=%b err=%b", ack, err);
                end else begin
                    mon_e = sb.pop_front();
                    oh = NREQ'(1) << mon_e.idx;
                    if (ack !== (mon_e.is_err ? '0 : oh) || err !== (mon_e.is_err ? oh : '0)
                        || rsp_data !== mon_e.data || cyc != mon_e.at) begin
                        errors++;
                        $display("FAIL response req%0d got ack=%b err=%b rsp=%h cyc=%0d expected err=%0b rsp=%h cyc=%0d",
                                 mon_e.idx, ack, err, rsp_data, cyc, mon_e.is_err, mon_e.data, mon_e.at);
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_rsp", 32'(rsp_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sfrwe", 32'(sfrwe), 0);
        chk("rst_waddr", 32'(sfraddr_w), 0);
        chk("rst_wdata", 32'(spidata_o), 0);
        chk("rst_raddr", 32'(sfraddr_r), 3);
        chk("rst_spssn", 32'(spssn), 32'hFF);
        rst_n = 1'b1;
        @(negedge clk);
        // single request, completion at WAIT cycle 4
        sr_mode = 0; sr_delay = 3;
        issue(0, 8'hA5, 3'd2, 8'h3C, 1'b0, cyc + 10);
        wait_done(40);
        // status already high: blanking holds READ until WAIT cycle 3
        sr_mode = 1;
        issue(1, 8'h5A, 3'd7, 8'hC3, 1'b0, cyc + 9);
        wait_done(40);
        // status never set: err after 15 WAIT cycles, rsp_data unchanged
        sr_mode = 2;
        issue(2, 8'h11, 3'd0, 8'hC3, 1'b1, cyc + 20);
        wait_done(60);
        // completion on the last WAIT cycle beats the timeout
        sr_mode = 0; sr_delay = 14;
        issue(3, 8'h24, 3'd4, 8'hBD, 1'b0, cyc + 21);
        wait_done(60);
        // all four at once: order 0,1,2,3 with one IDLE cycle between
        sr_delay = 3;
        issue(0, 8'h10, 3'd1, 8'h89, 1'b0, cyc + 10);
        issue(1, 8'h21, 3'd3, 8'hB8, 1'b0, cyc + 21);
        issue(2, 8'h32, 3'd5, 8'hAB, 1'b0, cyc + 32);
        issue(3, 8'h43, 3'd6, 8'hDA, 1'b0, cyc + 43);
        wait_done(120);
        // reset during WAIT, then the held request restarts from CR1
        sr_mode = 2;
        issue(0, 8'h77, 3'd1, 8'hEE, 1'b0, 0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_spssn", 32'(spssn), 32'hFF);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_ack", 32'(ack), 0);
        chk("midrst_err", 32'(err), 0);
        repeat (2) @(negedge clk);
        chk("inrst_pulses", 32'(ack | err), 0);
        push_wr(8'h77);
        sr_mode = 0; sr_delay = 3;
        sb[0].at = cyc + 10;
        rst_n = 1'b1;
        wait_done(40);
        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 0);
        chk("wq_empty", 32'(wq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
